// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-wide data RAM with a registered read port.
// Byte/half/word requests; sub-word stores use read-modify-write, loads are lane-selected and extended.
module mem_access_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // Request channel: a transfer happens on the posedge where req_valid && req_ready.
  // req_valid may be raised at any time; req_* only need to be stable in the accept cycle.
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [1:0]                 req_size,
  input  logic                       req_signed,
  input  logic [ADDRESS_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic                       resp_err,
  output logic                       ram_wEn,
  output logic [ADDRESS_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_dataIn,
  input  logic [DATA_WIDTH-1:0]      ram_dataOut,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DATA  = 3'd4
  } state_t;

  state_t                state, state_n;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept;
  logic                  misaligned;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;

  assign req_ready = (state == IDLE) && reset_n;
  assign accept    = req_valid && req_ready;
  assign ram_wEn   = (state == WRITE);
  assign dbg_state = state;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept && !misaligned) begin
          if (req_we && (req_size == 2'b10)) state_n = WRITE;
          else                               state_n = READ;
        end
      end
      READ:    state_n = we_q ? MERGE : DATA;
      MERGE:   state_n = WRITE;
      WRITE:   state_n = IDLE;
      DATA:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lane extraction for loads and lane insertion for sub-word stores, both off the RAM read word.
  always_comb begin
    lane_b   = ram_dataOut[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? ram_dataOut[31:16] : ram_dataOut[15:0];
    load_val = ram_dataOut;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_val = ram_dataOut;
    endcase
    merged = ram_dataOut;
    if (size_q == 2'b00) merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
    else                 merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      ram_addr   <= '0;
      ram_dataIn <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              ram_addr   <= req_addr[ADDRESS_WIDTH+1:2];
              ram_dataIn <= req_wdata;
            end
          end
        end
        MERGE: ram_dataIn <= merged;
        WRITE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        DATA: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic against a byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [13:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wen_cnt = 0;

  // Scoreboard: expected data, error flag and accept cycle for each accepted request.
  logic [31:0] exp_q[$];
  logic [0:0]  exp_err_q[$];
  int          exp_lat_q[$];
  int          exp_cyc_q[$];

  logic [7:0]  mb [0:255];
  logic [31:0] ram [0:4095];

  mem_access_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM: registered read, read only when not writing.
  always @(posedge clk) begin
    if (ram_wEn) begin
      ram[ram_addr] <= ram_dataIn;
      wen_cnt <= wen_cnt + 1;
    end else begin
      ram_dataOut <= ram[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, size in bytes, extension by arithmetic.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [13:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int lat);
    int nbytes;
    int a;
    longint v;
    nbytes = 1 << size;
    a = int'(addr[7:0]);
    err = (size == 2'd3) || (addr % nbytes != 0);
    rd = '0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) mb[a + i] = wdata[8*i +: 8];
      lat = (nbytes == 4) ? 2 : 4;
    end else begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v + (longint'(mb[a + i]) << (8 * i));
      if (sgn && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
        v = v - (longint'(1) << (8 * nbytes));
      rd = v[31:0];
      lat = 3;
    end
  endtask

  // Driver: present a request, wait for acceptance (scrambling fields while busy), log expectation.
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [13:0] addr, input logic [31:0] wdata,
                      input bit expect_resp, input bit overlap);
    int w;
    logic [31:0] rd;
    logic e;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      req_we = 1'($urandom);
      req_addr = 14'($urandom);
      req_wdata = $urandom;
      req_size = 2'($urandom);
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    if (overlap) check("b2b_accept_on_resp", 32'(resp_valid), 32'd1);
    if (expect_resp) begin
      model(we, size, sgn, addr, wdata, rd, e, lat);
      exp_q.push_back(rd);
      exp_err_q.push_back(e);
      exp_lat_q.push_back(lat);
      exp_cyc_q.push_back(cyc);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int w = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        check("resp_rdata", resp_rdata, exp_q.pop_front());
        check("resp_err", 32'(resp_err), 32'(exp_err_q.pop_front()));
        check("resp_latency", 32'(cyc - exp_cyc_q.pop_front()), 32'(exp_lat_q.pop_front()));
      end
    end
  end

  initial begin
    int wen_before;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_wen", 32'(ram_wEn), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_datain", ram_dataIn, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Prefill the modelled region with word stores
    for (int i = 0; i < 64; i++) send(1'b1, 2'b10, 1'b0, 14'(i * 4), $urandom, 1'b1, 1'b0);
    drain();

    // Word store then load
    send(1'b1, 2'b10, 1'b0, 14'h10, 32'h11223344, 1'b1, 1'b0);
    send(1'b0, 2'b10, 1'b0, 14'h10, 32'h0, 1'b1, 1'b0);
    // Byte store merge
    send(1'b1, 2'b00, 1'b0, 14'h11, 32'hFFFFFFAB, 1'b1, 1'b0);
    send(1'b0, 2'b10, 1'b0, 14'h10, 32'h0, 1'b1, 1'b0);
    // Extension
    send(1'b1, 2'b10, 1'b0, 14'h20, 32'h00008080, 1'b1, 1'b0);
    send(1'b0, 2'b00, 1'b1, 14'h20, 32'h0, 1'b1, 1'b0);
    send(1'b0, 2'b00, 1'b0, 14'h20, 32'h0, 1'b1, 1'b0);
    send(1'b0, 2'b01, 1'b1, 14'h20, 32'h0, 1'b1, 1'b0);
    send(1'b0, 2'b01, 1'b0, 14'h22, 32'h0, 1'b1, 1'b0);
    drain();

    // Errors never write
    wen_before = wen_cnt;
    send(1'b0, 2'b10, 1'b0, 14'h22, 32'h0, 1'b1, 1'b0);
    send(1'b1, 2'b01, 1'b0, 14'h21, 32'h5555, 1'b1, 1'b0);
    send(1'b1, 2'b11, 1'b0, 14'h20, 32'h77777777, 1'b1, 1'b0);
    drain();
    check("err_no_wen", 32'(wen_cnt), 32'(wen_before));
    send(1'b0, 2'b10, 1'b0, 14'h20, 32'h0, 1'b1, 1'b0);
    drain();

    // Back-to-back with req_valid held
    send(1'b1, 2'b10, 1'b0, 14'h40, 32'hCAFEF00D, 1'b1, 1'b0);
    send(1'b0, 2'b01, 1'b1, 14'h42, 32'h0, 1'b1, 1'b1);
    send(1'b1, 2'b00, 1'b0, 14'h43, 32'h12, 1'b1, 1'b1);
    send(1'b1, 2'b10, 1'b0, 14'h45, 32'h0, 1'b1, 1'b1);
    send(1'b0, 2'b10, 1'b0, 14'h40, 32'h0, 1'b1, 1'b1);
    drain();

    // Reset during MERGE of a half store
    send(1'b1, 2'b10, 1'b0, 14'h30, 32'hDEADBEEF, 1'b1, 1'b0);
    drain();
    send(1'b1, 2'b01, 1'b0, 14'h30, 32'h00001234, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_merge", 32'(dbg_state), 32'd2);
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("abort_wen", 32'(ram_wEn), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_resp", 32'(resp_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_wen", 32'(ram_wEn), 32'd0);
    end
    reset_n = 1'b1;
    send(1'b0, 2'b10, 1'b0, 14'h30, 32'h0, 1'b1, 1'b0);
    drain();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      send(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           14'($urandom_range(0, 255)), $urandom, 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    drain();

    // Final memory image against the model
    for (int i = 0; i < 64; i++)
      check("mem_image", ram[i], {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
